// File: rtl/assoc_data_array_if.sv
// Controller-side bundle for the set-associative data array: addressing, hit vector,
// read/write commands, and the read/victim/error returns.
interface assoc_data_array_if #(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned SETS   = 8,
  parameter int unsigned LINE_W = 128
);
  localparam int unsigned SET_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  logic [SET_W-1:0]    set_idx;
  logic [WAYS-1:0]     hit_vec;
  logic                rd_en;
  logic                load;
  logic [LINE_W/8-1:0] load_mask;
  logic [LINE_W-1:0]   in;
  logic [LINE_W-1:0]   rd_data;
  logic                rd_valid;
  logic [WAY_W-1:0]    victim_way;
  logic                multi_hit;

  modport master (
    output set_idx, hit_vec, rd_en, load, load_mask, in,
    input  rd_data, rd_valid, victim_way, multi_hit
  );

  modport slave (
    input  set_idx, hit_vec, rd_en, load, load_mask, in,
    output rd_data, rd_valid, victim_way, multi_hit
  );
endinterface

// File: rtl/assoc_data_array.sv
// N-way set-associative cache data store with byte-masked writes, registered read port
// and per-set tree pseudo-LRU victim selection.
module assoc_data_array #(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned SETS   = 8,
  parameter int unsigned LINE_W = 128
) (
  input logic             clk,
  input logic             reset_n,
  assoc_data_array_if.slave bus
);
  localparam int unsigned SET_W  = $clog2(SETS);
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned MASK_W = LINE_W / 8;

  logic [LINE_W-1:0] mem_q [SETS][WAYS];
  logic [WAYS-2:0]   plru_q [SETS];
  logic [LINE_W-1:0] rd_data_q;
  logic              rd_valid_q, multi_hit_q;

  logic [SET_W-1:0]  set_s;
  logic              hit_none, hit_single, hit_multi;
  logic [WAY_W-1:0]  hit_way, victim, tgt_way;
  logic [WAY_W-1:0]  vnode, unode;
  logic              vbit, ubit;
  logic [WAYS-2:0]   plru_cur, plru_d;
  logic [LINE_W-1:0] old_line, line_d;
  logic              wr_ok, rd_ok, acc_ok;

  assign set_s      = bus.set_idx;
  assign hit_none   = ~|bus.hit_vec;
  assign hit_single = $onehot(bus.hit_vec);
  assign hit_multi  = ~hit_none & ~hit_single;
  assign plru_cur   = plru_q[set_s];

  always_comb begin
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (bus.hit_vec[i]) hit_way = WAY_W'(i);
    end
  end

  // Walk the heap-ordered tree from the root; children of node n are 2n+1 and 2n+2.
  always_comb begin
    victim = '0;
    vnode  = '0;
    vbit   = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      vbit   = plru_cur[vnode];
      victim = (victim << 1) | WAY_W'(vbit);
      vnode  = (vnode << 1) + WAY_W'(vbit) + WAY_W'(1);
    end
  end

  assign tgt_way  = hit_single ? hit_way : victim;
  assign old_line = mem_q[set_s][tgt_way];

  for (genvar gb = 0; gb < MASK_W; gb++) begin : g_merge
    assign line_d[8*gb +: 8] = bus.load_mask[gb] ? bus.in[8*gb +: 8] : old_line[8*gb +: 8];
  end

  assign wr_ok  = bus.load & ~hit_multi;
  assign rd_ok  = bus.rd_en & ~hit_multi & (hit_single | bus.load);
  assign acc_ok = wr_ok | (bus.rd_en & hit_single);

  // Point every node on the accessed way's path away from it.
  always_comb begin
    plru_d = plru_cur;
    unode  = '0;
    ubit   = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      ubit          = |((tgt_way >> (int'(WAY_W) - 1 - lvl)) & WAY_W'(1));
      plru_d[unode] = ~ubit;
      unode         = (unode << 1) + WAY_W'(ubit) + WAY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) mem_q[s][w] <= '0;
      end
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      multi_hit_q <= 1'b0;
    end else begin
      if (wr_ok)  mem_q[set_s][tgt_way] <= line_d;
      if (acc_ok) plru_q[set_s] <= plru_d;
      // Write-first: a same-edge read returns the merged line.
      if (rd_ok)  rd_data_q <= bus.load ? line_d : old_line;
      rd_valid_q  <= rd_ok;
      multi_hit_q <= hit_multi & (bus.load | bus.rd_en);
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.multi_hit  = multi_hit_q;
  assign bus.victim_way = victim;
endmodule
